// File: rtl/pit_wb_pkg.sv
// rtl/pit_wb_pkg.sv - shared types and helpers for the PIT WISHBONE register slave
package pit_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } pit_state_t;

    function automatic int lanes(input int dwidth);
        return dwidth / 8;
    endfunction

    function automatic bit params_legal(input int dwidth, input int num_bytes, input int wait_states);
        return (dwidth == 8 || dwidth == 16 || dwidth == 32) &&
               (num_bytes >= 1) && (num_bytes <= 32) &&
               (wait_states >= 0) && (wait_states <= 7);
    endfunction

endpackage

// File: rtl/pit_wb_wait_ctr.sv
// rtl/pit_wb_wait_ctr.sv - 3-bit wait-state down-counter with load and zero flag
module pit_wb_wait_ctr (
    input  logic       wb_clk_i,
    input  logic       async_rst_b,
    input  logic       clear,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count;

    always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
        if (!async_rst_b) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/pit_wb_slave.sv
// rtl/pit_wb_slave.sv - WISHBONE slave exposing NUM_BYTES byte registers with wait states
module pit_wb_slave
    import pit_wb_pkg::*;
#(
    parameter int DWIDTH      = 16,
    parameter int NUM_BYTES   = 6,
    parameter int WAIT_STATES = 1,
    parameter int AWIDTH      = 3
) (
    input  logic                   wb_clk_i,
    input  logic                   async_rst_b,
    input  logic                   wb_rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [AWIDTH-1:0]      wb_adr_i,
    input  logic [DWIDTH/8-1:0]    wb_sel_i,
    input  logic [DWIDTH-1:0]      wb_dat_i,
    output logic [DWIDTH-1:0]      wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [NUM_BYTES-1:0]   reg_we,
    output logic [8*NUM_BYTES-1:0] reg_wdata,
    output logic [NUM_BYTES-1:0]   reg_re,
    input  logic [8*NUM_BYTES-1:0] read_regs
);

    localparam int          LN       = lanes(DWIDTH);
    localparam int unsigned LN_U     = LN;
    localparam int unsigned NB_U     = NUM_BYTES;
    localparam logic [2:0]  LOAD_VAL = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    if (!params_legal(DWIDTH, NUM_BYTES, WAIT_STATES)) begin : g_bad_params
        $error("pit_wb_slave: illegal parameter combination");
    end

    pit_state_t          state;
    pit_state_t          next_state;
    logic                module_sel;
    logic                latch;
    logic                ctr_load;
    logic                ctr_dec;
    logic                ctr_zero;
    logic [AWIDTH-1:0]   adr_q;
    logic [LN-1:0]       sel_q;
    logic                we_q;
    logic [DWIDTH-1:0]   dat_q;
    logic [DWIDTH-1:0]   dat_o_q;
    logic [AWIDTH-1:0]   eff_adr;
    logic [LN-1:0]       eff_sel;
    logic                eff_we;
    logic                err_q;
    logic                err_eff;
    logic [NUM_BYTES-1:0] hit_q;
    logic [NUM_BYTES-1:0] hit_eff;
    logic [DWIDTH-1:0]   rdata;
    logic                term_ok;

    assign module_sel = wb_cyc_i & wb_stb_i;
    assign latch      = (state == IDLE) && module_sel;

    // In IDLE the bus inputs are the access being latched this cycle, so a
    // zero-wait read can still register its data on the way into TERM.
    assign eff_adr = (state == IDLE) ? wb_adr_i : adr_q;
    assign eff_sel = (state == IDLE) ? wb_sel_i : sel_q;
    assign eff_we  = (state == IDLE) ? wb_we_i  : we_q;

    assign err_q   = ((32'(adr_q)   * LN_U) >= NB_U) || (sel_q   == '0);
    assign err_eff = ((32'(eff_adr) * LN_U) >= NB_U) || (eff_sel == '0);

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_byte
        localparam int unsigned LANE = k % LN;
        localparam int unsigned WORD = k / LN;
        assign hit_q[k]              = (32'(adr_q)   == WORD) && sel_q[LANE];
        assign hit_eff[k]            = (32'(eff_adr) == WORD) && eff_sel[LANE];
        assign reg_wdata[8*k +: 8]   = dat_q[8*LANE +: 8];
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (hit_eff[k]) begin
                rdata[8*(k % LN) +: 8] = read_regs[8*k +: 8];
            end
        end
    end

    pit_wb_wait_ctr u_wait_ctr (
        .wb_clk_i    (wb_clk_i),
        .async_rst_b (async_rst_b),
        .clear       (wb_rst_i),
        .load        (ctr_load),
        .load_val    (LOAD_VAL),
        .dec         (ctr_dec),
        .zero        (ctr_zero)
    );

    always_comb begin
        next_state = state;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (module_sel) begin
                    ctr_load   = 1'b1;
                    next_state = (WAIT_STATES > 0) ? WAIT : TERM;
                end
            end
            WAIT: begin
                if (!module_sel) begin
                    next_state = IDLE;
                end else if (ctr_zero) begin
                    next_state = TERM;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            TERM:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
        if (!async_rst_b) begin
            state   <= IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            dat_o_q <= '0;
        end else if (wb_rst_i) begin
            state   <= IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            dat_o_q <= '0;
        end else begin
            state <= next_state;
            if (latch) begin
                adr_q <= wb_adr_i;
                sel_q <= wb_sel_i;
                we_q  <= wb_we_i;
                dat_q <= wb_dat_i;
            end
            dat_o_q <= ((next_state == TERM) && !eff_we && !err_eff) ? rdata : '0;
        end
    end

    assign term_ok  = (state == TERM) && module_sel;
    assign wb_ack_o = term_ok && !err_q;
    assign wb_err_o = term_ok && err_q;
    assign reg_we   = (wb_ack_o &&  we_q) ? hit_q : '0;
    assign reg_re   = (wb_ack_o && !we_q) ? hit_q : '0;
    assign wb_dat_o = dat_o_q;

endmodule

// File: tb/tb_pit_wb_slave.sv
// tb/tb_pit_wb_slave.sv - self-checking bench for pit_wb_slave in three bus configurations
module tb_pit_wb_slave;

    localparam int WS_OF[3] = '{1, 3, 0};
    localparam int LN_OF[3] = '{2, 1, 4};

    logic        clk;
    logic        async_rst_b;
    logic        wb_rst_i;
    logic        cyc[3];
    logic        stb[3];
    logic        we_i[3];
    logic [2:0]  adr[3];
    logic [3:0]  sel[3];
    logic [31:0] dat_i[3];
    logic        ack[3];
    logic        err[3];
    logic [5:0]  reg_we[3];
    logic [5:0]  reg_re[3];
    logic [47:0] wdata[3];
    logic [47:0] read_regs;
    logic [15:0] dat_o_a;
    logic [7:0]  dat_o_b;
    logic [31:0] dat_o_c;

    int n_asserts = 0;
    int n_fail    = 0;

    pit_wb_slave #(.DWIDTH(16), .NUM_BYTES(6), .WAIT_STATES(1), .AWIDTH(3)) u_dut_a (
        .wb_clk_i(clk), .async_rst_b(async_rst_b), .wb_rst_i(wb_rst_i),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we_i[0]), .wb_adr_i(adr[0]),
        .wb_sel_i(sel[0][1:0]), .wb_dat_i(dat_i[0][15:0]), .wb_dat_o(dat_o_a),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .reg_we(reg_we[0]), .reg_wdata(wdata[0]),
        .reg_re(reg_re[0]), .read_regs(read_regs)
    );

    pit_wb_slave #(.DWIDTH(8), .NUM_BYTES(6), .WAIT_STATES(3), .AWIDTH(3)) u_dut_b (
        .wb_clk_i(clk), .async_rst_b(async_rst_b), .wb_rst_i(wb_rst_i),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we_i[1]), .wb_adr_i(adr[1]),
        .wb_sel_i(sel[1][0:0]), .wb_dat_i(dat_i[1][7:0]), .wb_dat_o(dat_o_b),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .reg_we(reg_we[1]), .reg_wdata(wdata[1]),
        .reg_re(reg_re[1]), .read_regs(read_regs)
    );

    pit_wb_slave #(.DWIDTH(32), .NUM_BYTES(6), .WAIT_STATES(0), .AWIDTH(3)) u_dut_c (
        .wb_clk_i(clk), .async_rst_b(async_rst_b), .wb_rst_i(wb_rst_i),
        .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we_i[2]), .wb_adr_i(adr[2]),
        .wb_sel_i(sel[2]), .wb_dat_i(dat_i[2]), .wb_dat_o(dat_o_c),
        .wb_ack_o(ack[2]), .wb_err_o(err[2]), .reg_we(reg_we[2]), .reg_wdata(wdata[2]),
        .reg_re(reg_re[2]), .read_regs(read_regs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] get_dat(input int u);
        case (u)
            0:       return {16'h0, dat_o_a};
            1:       return {24'h0, dat_o_b};
            default: return dat_o_c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each selected lane maps to byte address*lanes+lane; bytes past the end are dropped.
    task automatic model(input int u, input logic [2:0] a, input logic [3:0] s, input logic w,
                         input logic [31:0] d, output logic e, output logic [5:0] wm,
                         output logic [5:0] rm, output logic [31:0] rd,
                         output logic [47:0] wd, output logic [47:0] wd_mask);
        int n;
        int idx;
        logic [5:0] mask;
        n       = LN_OF[u];
        e       = ((int'(a) * n) >= 6) || ((int'(s) & ((1 << n) - 1)) == 0);
        mask    = '0;
        rd      = '0;
        wd      = '0;
        wd_mask = '0;
        for (int l = 0; l < n; l++) begin
            idx = int'(a) * n + l;
            if (s[l] && idx < 6) begin
                mask[idx]           = 1'b1;
                rd[8*l +: 8]        = read_regs[8*idx +: 8];
                wd[8*idx +: 8]      = d[8*l +: 8];
                wd_mask[8*idx +: 8] = 8'hFF;
            end
        end
        wm = (w && !e) ? mask : 6'h0;
        rm = (!w && !e) ? mask : 6'h0;
        if (w || e) rd = '0;
        if (!w || e) wd_mask = '0;
    endtask

    task automatic do_access(input int u, input logic [2:0] a, input logic [3:0] s,
                             input logic w, input logic [31:0] d);
        logic        e;
        logic [5:0]  wm, rm;
        logic [31:0] rd;
        logic [47:0] wd, wdm;
        model(u, a, s, w, d, e, wm, rm, rd, wd, wdm);
        @(posedge clk); #1;
        cyc[u] = 1'b1; stb[u] = 1'b1; adr[u] = a; sel[u] = s; we_i[u] = w; dat_i[u] = d;
        for (int c = 0; c <= WS_OF[u] + 1; c++) begin
            @(negedge clk);
            if (c <= WS_OF[u]) begin
                check("early_term_or_strobe", {ack[u], err[u], reg_we[u], reg_re[u]}, 14'h0);
            end else begin
                check("ack", ack[u], !e);
                check("err", err[u], e);
                check("reg_we", reg_we[u], wm);
                check("reg_re", reg_re[u], rm);
                check("dat_o", get_dat(u), rd);
                check("reg_wdata", wdata[u] & wdm, wd & wdm);
            end
        end
        @(posedge clk); #1;
        cyc[u] = 1'b0; stb[u] = 1'b0;
        @(negedge clk);
        check("idle_after_term", {ack[u], err[u], get_dat(u)}, 34'h0);
    endtask

    task automatic check_all_quiet(input string tag);
        for (int u = 0; u < 3; u++) begin
            check(tag, {ack[u], err[u], reg_we[u], reg_re[u], get_dat(u)}, 46'h0);
        end
    endtask

    initial begin
        async_rst_b = 1'b0;
        wb_rst_i    = 1'b0;
        read_regs   = '0;
        for (int u = 0; u < 3; u++) begin
            cyc[u] = 1'b0; stb[u] = 1'b0; we_i[u] = 1'b0;
            adr[u] = '0;   sel[u] = '0;   dat_i[u] = '0;
        end
        #12;
        check_all_quiet("reset_state");
        async_rst_b = 1'b1;

        // 16-bit write of the example word to address 0
        do_access(0, 3'd0, 4'b0011, 1'b1, 32'h0000_A55A);
        // 8-bit, three wait states, read of the top byte
        read_regs = 48'h3C00_0000_0000;
        do_access(1, 3'd5, 4'b0001, 1'b0, 32'h0);
        // 32-bit partial top word, then a word wholly past the end
        read_regs = 48'h1122_3344_5566;
        do_access(2, 3'd1, 4'b1111, 1'b1, 32'hDEAD_BEEF);
        do_access(2, 3'd1, 4'b1111, 1'b0, 32'h0);
        do_access(2, 3'd2, 4'b1111, 1'b0, 32'h0);
        do_access(0, 3'd1, 4'b0000, 1'b1, 32'h1234);

        // Abort: strobe dropped during the wait phase
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 3'd2; sel[1] = 4'h1; we_i[1] = 1'b1; dat_i[1] = 32'h77;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        stb[1] = 1'b0;
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            check("abort_quiet", {ack[1], err[1], reg_we[1], reg_re[1]}, 14'h0);
        end
        cyc[1] = 1'b0;
        do_access(1, 3'd2, 4'h1, 1'b1, 32'h77);

        // Synchronous reset while waiting kills the access
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 3'd0; sel[0] = 4'h3; we_i[0] = 1'b1; dat_i[0] = 32'h5555;
        @(posedge clk); #1;
        wb_rst_i = 1'b1;
        @(negedge clk);
        check("sync_rst_wait", {ack[0], err[0], reg_we[0]}, 8'h0);
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        @(negedge clk);
        check("sync_rst_no_term", {ack[0], err[0], reg_we[0], reg_re[0]}, 14'h0);
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        check("sync_rst_after", {ack[0], err[0], reg_we[0]}, 8'h0);

        // Asynchronous reset in the middle of TERM
        @(posedge clk); #1;
        cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 3'd1; sel[0] = 4'h3; we_i[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("term_before_async", ack[0], 1'b1);
        async_rst_b = 1'b0;
        #1;
        check_all_quiet("async_rst_mid_term");
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        async_rst_b = 1'b1;
        @(negedge clk);
        check_all_quiet("after_async_rst");

        // Zero wait states with strobe held: back-to-back two-cycle accesses
        @(posedge clk); #1;
        cyc[2] = 1'b1; stb[2] = 1'b1; adr[2] = 3'd0; sel[2] = 4'hF; we_i[2] = 1'b1; dat_i[2] = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("b2b_ack", ack[2], (c % 2) == 1);
            check("b2b_reg_we", reg_we[2], ((c % 2) == 1) ? 6'b001111 : 6'b000000);
        end
        @(posedge clk); #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;

        // Randomized accesses against the reference model
        for (int i = 0; i < 45; i++) begin
            read_regs = {16'($urandom), $urandom};
            do_access(i % 3, 3'($urandom_range(0, 7)), 4'($urandom), 1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
